kernel_axis_serializer: RTL and testbench

- Downstream neighbour of the 64-pixel kernel collector.
- Captures each completed image kernel (flat pixel array plus odd-kernel flag) into a ping-pong buffer and remaps pixel order: even kernels in order, odd kernels reversed.
- Replays pixels one per beat as an AXI4-Stream master with backpressure, tuser on start of frame and tlast at end of line.

---
 rtl/kernel_remap_pkg.sv | 35 +++
 rtl/kernel_pingpong_buf.sv | 72 +++++++
 rtl/kernel_axis_serializer.sv | 179 +++++++++++++++++
 tb/tb_kernel_axis_serializer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_remap_pkg.sv
// ============================================================================
// Module  : kernel_remap_pkg
// Brief   : Shared types, widths and pixel-order remap helper for the
//           kernel AXI4-Stream serializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package kernel_remap_pkg;

  localparam int unsigned KSER_KERNEL_PIX       = 64;
  localparam int unsigned KSER_KERNELS_PER_LINE = 192;
  localparam int unsigned PIX_IDX_W             = $clog2(KSER_KERNEL_PIX);
  localparam int unsigned LINE_CNT_W            = $clog2(KSER_KERNELS_PER_LINE);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } kser_state_t;

  typedef struct packed {
    logic full;
    logic odd;
    logic sof;
  } bank_meta_t;

  // Kernel size is a power of two, so N-1-idx is the bitwise complement.
  function automatic logic [PIX_IDX_W-1:0] remap_idx(input logic [PIX_IDX_W-1:0] idx,
                                                     input logic                 odd);
    return odd ? ~idx : idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kernel_pingpong_buf.sv
// ============================================================================
// Module  : kernel_pingpong_buf
// Brief   : Two-bank kernel store with full/odd/sof tags and write/read
//           bank pointers; accepts into a bank freed on the same edge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module kernel_pingpong_buf
  import kernel_remap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned IMAGE_KERNEL_12K = 64,
  localparam int unsigned PIX_W           = $clog2(IMAGE_KERNEL_12K)
) (
  input  logic                                         i_clk,
  input  logic                                         i_aresetn,
  input  logic                                         i_wr_strobe,
  input  logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0]  i_wr_kernel,
  input  logic                                         i_wr_odd,
  input  logic                                         i_wr_sof,
  input  logic                                         i_rd_release,
  input  logic                                         i_rd_bank_sel,
  input  logic [PIX_W-1:0]                             i_rd_addr,
  output logic [DATA_WIDTH-1:0]                        o_rd_pixel,
  output logic                                         o_rd_bank,
  output bank_meta_t [1:0]                             o_meta,
  output logic                                         o_drop
);

  logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0] r_bank [2];
  bank_meta_t [1:0]                            r_meta;
  logic                                        r_wr_bank;
  logic                                        r_rd_bank;
  logic                                        w_free;
  logic                                        w_accept;

  assign w_free   = !r_meta[r_wr_bank].full || (i_rd_release && (r_rd_bank == r_wr_bank));
  assign w_accept = i_wr_strobe && w_free;
  assign o_drop   = i_wr_strobe && !w_free;

  // A release and a capture on the same bank leave it full with new tags.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_meta    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      if (i_rd_release) begin
        r_meta[r_rd_bank].full <= 1'b0;
        r_rd_bank              <= ~r_rd_bank;
      end
      if (w_accept) begin
        r_meta[r_wr_bank] <= '{full: 1'b1, odd: i_wr_odd, sof: i_wr_sof};
        r_wr_bank         <= ~r_wr_bank;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_bank[r_wr_bank] <= i_wr_kernel;
    end
  end

  assign o_rd_pixel = r_bank[i_rd_bank_sel][i_rd_addr];
  assign o_rd_bank  = r_rd_bank;
  assign o_meta     = r_meta;

endmodule

`default_nettype wire

// File: rtl/kernel_axis_serializer.sv
// ============================================================================
// Module  : kernel_axis_serializer
// Brief   : Replays ping-pong buffered kernels as an AXI4-Stream master with
//           odd-kernel reversal, tuser on SOF and tlast at end of line.
//           Optional KSER_OVF_COUNT_EN adds a saturating drop counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module kernel_axis_serializer
  import kernel_remap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned IMAGE_KERNEL_12K = 64,
  parameter int unsigned KERNELS_PER_LINE = 192
) (
  input  logic                                         i_clk,
  input  logic                                         i_aresetn,
  input  logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0]  i_image_kernel,
  input  logic                                         i_kernel_is_ready,
  input  logic                                         i_kernel_is_odd,
  input  logic                                         i_kernel_sof,
  output logic [DATA_WIDTH-1:0]                        o_axis_tdata,
  output logic                                         o_axis_tvalid,
  input  logic                                         i_axis_tready,
  output logic                                         o_axis_tuser,
  output logic                                         o_axis_tlast,
  output logic                                         o_overflow
`ifdef KSER_OVF_COUNT_EN
  ,
  output logic [15:0]                                  o_overflow_cnt
`endif
);

  localparam int unsigned     PIX_W       = $clog2(IMAGE_KERNEL_12K);
  localparam int unsigned     LCW         = $clog2(KERNELS_PER_LINE);
  localparam logic [PIX_W-1:0] C_PIX_LAST  = PIX_W'(IMAGE_KERNEL_12K - 1);
  localparam logic [LCW-1:0]   C_KCNT_LAST = LCW'(KERNELS_PER_LINE - 1);

  kser_state_t       r_state, w_state_nxt;
  logic [PIX_W-1:0]  r_pix_idx, w_pix_nxt, w_rd_addr;
  logic [LCW-1:0]    r_line_kcnt, w_line_kcnt_nxt;
  logic [LCW-1:0]    w_eff_cur, w_kcnt_after, w_base, w_eff_nxt;
  logic              r_tvalid, r_tuser, r_tlast, r_overflow;
  logic [DATA_WIDTH-1:0] r_tdata, w_rd_pixel;
  logic              w_valid_nxt, w_load, w_sel, w_release, w_beat;
  logic              w_user_nxt, w_last_nxt, w_rd_bank, w_drop;
  bank_meta_t [1:0]  w_meta;
  bank_meta_t        w_nxt_meta;

  kernel_pingpong_buf #(
    .DATA_WIDTH       (DATA_WIDTH),
    .IMAGE_KERNEL_12K (IMAGE_KERNEL_12K)
  ) u_buf (
    .i_clk         (i_clk),
    .i_aresetn     (i_aresetn),
    .i_wr_strobe   (i_kernel_is_ready),
    .i_wr_kernel   (i_image_kernel),
    .i_wr_odd      (i_kernel_is_odd),
    .i_wr_sof      (i_kernel_sof),
    .i_rd_release  (w_release),
    .i_rd_bank_sel (w_sel),
    .i_rd_addr     (w_rd_addr),
    .o_rd_pixel    (w_rd_pixel),
    .o_rd_bank     (w_rd_bank),
    .o_meta        (w_meta),
    .o_drop        (w_drop)
  );

  assign w_beat = r_tvalid && i_axis_tready;

  // Next-beat selection: the output registers always hold the pixel on offer,
  // so the mux looks one beat ahead (same kernel, or the other bank on wrap).
  always_comb begin
    w_state_nxt     = r_state;
    w_pix_nxt       = r_pix_idx;
    w_line_kcnt_nxt = r_line_kcnt;
    w_valid_nxt     = r_tvalid;
    w_load          = 1'b0;
    w_release       = 1'b0;
    w_sel           = w_rd_bank;
    w_eff_cur       = w_meta[w_rd_bank].sof ? '0 : r_line_kcnt;
    w_kcnt_after    = (w_eff_cur == C_KCNT_LAST) ? '0 : w_eff_cur + 1'b1;
    w_base          = r_line_kcnt;
    case (r_state)
      IDLE: begin
        if (w_meta[w_rd_bank].full) begin
          w_state_nxt = STREAM;
          w_valid_nxt = 1'b1;
          w_load      = 1'b1;
          w_pix_nxt   = '0;
        end
      end
      STREAM: begin
        if (w_beat) begin
          if (r_pix_idx == C_PIX_LAST) begin
            w_release       = 1'b1;
            w_line_kcnt_nxt = w_kcnt_after;
            w_base          = w_kcnt_after;
            w_sel           = ~w_rd_bank;
            w_pix_nxt       = '0;
            if (w_meta[~w_rd_bank].full) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = IDLE;
              w_valid_nxt = 1'b0;
            end
          end else begin
            w_pix_nxt = r_pix_idx + 1'b1;
            w_load    = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_nxt_meta = w_meta[w_sel];
    w_eff_nxt  = w_nxt_meta.sof ? '0 : w_base;
    w_user_nxt = (w_pix_nxt == '0) && w_nxt_meta.sof;
    w_last_nxt = (w_pix_nxt == C_PIX_LAST) && (w_eff_nxt == C_KCNT_LAST);
  end

  generate
    if (PIX_W == PIX_IDX_W) begin : g_remap_pkg
      assign w_rd_addr = remap_idx(w_pix_nxt, w_nxt_meta.odd);
    end else begin : g_remap_local
      assign w_rd_addr = w_nxt_meta.odd ? ~w_pix_nxt : w_pix_nxt;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state     <= IDLE;
      r_pix_idx   <= '0;
      r_line_kcnt <= '0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tuser     <= 1'b0;
      r_tlast     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pix_idx   <= w_pix_nxt;
      r_line_kcnt <= w_line_kcnt_nxt;
      r_tvalid    <= w_valid_nxt;
      r_overflow  <= w_drop;
      if (w_load) begin
        r_tdata <= w_rd_pixel;
        r_tuser <= w_user_nxt;
        r_tlast <= w_last_nxt;
      end else if (!w_valid_nxt) begin
        r_tuser <= 1'b0;
        r_tlast <= 1'b0;
      end
    end
  end

`ifdef KSER_OVF_COUNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign o_overflow_cnt = r_ovf_cnt;
`endif

  assign o_axis_tdata  = r_tdata;
  assign o_axis_tvalid = r_tvalid;
  assign o_axis_tuser  = r_tuser;
  assign o_axis_tlast  = r_tlast;
  assign o_overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_kernel_axis_serializer.sv
// ============================================================================
// Module  : tb_kernel_axis_serializer
// Brief   : Directed bench for kernel_axis_serializer with a beat-order model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kernel_axis_serializer;

  localparam int N   = 64;
  localparam int KPL = 192;

  logic              clk;
  logic              aresetn;
  logic [0:N-1][7:0] kern;
  logic              rdy, kodd, ksof, tready;
  logic [7:0]        tdata;
  logic              tvalid, tuser, tlast, ovf;

  kernel_axis_serializer #(
    .DATA_WIDTH       (8),
    .IMAGE_KERNEL_12K (N),
    .KERNELS_PER_LINE (KPL)
  ) dut (
    .i_clk             (clk),
    .i_aresetn         (aresetn),
    .i_image_kernel    (kern),
    .i_kernel_is_ready (rdy),
    .i_kernel_is_odd   (kodd),
    .i_kernel_sof      (ksof),
    .o_axis_tdata      (tdata),
    .o_axis_tvalid     (tvalid),
    .i_axis_tready     (tready),
    .o_axis_tuser      (tuser),
    .o_axis_tlast      (tlast),
    .o_overflow        (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_assert = 0;
  int   n_fail   = 0;
  logic [7:0] exp_data [$];
  bit   exp_user [$];
  bit   exp_last [$];
  int   kcnt = 0;
  int   beats = 0;
  int   ovf_seen = 0;
  int   users_seen = 0;
  int   lasts_seen = 0;
  int   last_pos = -1;
  bit   prev_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive tready, then check what will be transferred at the next edge.
  task automatic step(input int rmode);
    logic [7:0] ed;
    bit eu, el;
    @(negedge clk);
    if (rmode == 2) tready = 1'($urandom_range(0, 1));
    else            tready = (rmode == 1);
    if (ovf) ovf_seen++;
    if (prev_stall && aresetn) chk("stall_valid", 32'(tvalid), 32'd1);
    if (tvalid && !tready && exp_data.size() != 0) begin
      chk("stall_data", 32'(tdata), 32'(exp_data[0]));
      chk("stall_user", 32'(tuser), 32'(exp_user[0]));
      chk("stall_last", 32'(tlast), 32'(exp_last[0]));
    end
    if (tvalid && tready) begin
      if (exp_data.size() == 0) begin
        chk("extra_beat", 32'd1, 32'd0);
      end else begin
        ed = exp_data.pop_front();
        eu = exp_user.pop_front();
        el = exp_last.pop_front();
        chk("tdata", 32'(tdata), 32'(ed));
        chk("tuser", 32'(tuser), 32'(eu));
        chk("tlast", 32'(tlast), 32'(el));
      end
      if (tuser) users_seen++;
      if (tlast) begin
        lasts_seen++;
        last_pos = beats;
      end
      beats++;
    end
    prev_stall = tvalid && !tready;
  endtask

  // Present a kernel for one cycle; optionally record its expected beats.
  task automatic send(input logic [7:0] base, input bit odd, input bit sof,
                      input bit push, input int rmode);
    int eff;
    bit lst;
    for (int i = 0; i < N; i++) kern[i] = 8'(base + 8'(i));
    kodd = odd;
    ksof = sof;
    if (push) begin
      eff  = sof ? 0 : kcnt;
      lst  = (eff == KPL - 1);
      kcnt = lst ? 0 : eff + 1;
      for (int j = 0; j < N; j++) begin
        exp_data.push_back(8'(base + 8'(odd ? (N - 1 - j) : j)));
        exp_user.push_back(sof && (j == 0));
        exp_last.push_back(lst && (j == N - 1));
      end
    end
    rdy = 1'b1;
    step(rmode);
    rdy = 1'b0;
  endtask

  task automatic drain(input string tag, input int rmode);
    int n;
    n = 0;
    while (exp_data.size() != 0 && n < 4000) begin
      step(rmode);
      n++;
    end
    chk({tag, "_drained"}, 32'(exp_data.size()), 32'd0);
    step(rmode);
    step(rmode);
    chk({tag, "_idle"}, 32'(tvalid), 32'd0);
  endtask

  initial begin
    int b0, o0, k, cyc;
    aresetn = 1'b0;
    rdy = 1'b0; kodd = 1'b0; ksof = 1'b0; tready = 1'b0;
    kern = '0;

    // Reset state
    step(0);
    step(0);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tdata", 32'(tdata), 32'd0);
    chk("rst_tuser", 32'(tuser), 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    aresetn = 1'b1;
    step(0);

    // Single even kernel with SOF, one-cycle latency to first beat
    b0 = beats;
    send(8'h00, 1'b0, 1'b1, 1'b1, 1);
    chk("lat_idle", 32'(tvalid), 32'd0);
    step(1);
    chk("lat_first", 32'(tvalid), 32'd1);
    drain("even", 1);
    chk("even_beats", 32'(beats - b0), 32'd64);
    chk("even_nolast", 32'(lasts_seen), 32'd0);

    // Single odd kernel, reversed
    send(8'h00, 1'b1, 1'b0, 1'b1, 1);
    drain("odd", 1);

    // Three kernels under backpressure: third dropped, then 128 beats gap-free
    o0 = ovf_seen;
    send(8'h10, 1'b0, 1'b0, 1'b1, 0);
    step(0);
    send(8'h50, 1'b1, 1'b0, 1'b1, 0);
    step(0);
    send(8'h90, 1'b0, 1'b0, 1'b0, 0);
    step(0);
    step(0);
    chk("drop_ovf", 32'(ovf_seen - o0), 32'd1);
    b0 = beats;
    for (int i = 0; i < 2 * N; i++) step(1);
    chk("drop_nobubble", 32'(beats - b0), 32'd128);
    drain("drop", 1);

    // Strobe coincident with the final handshake while both banks are full
    o0 = ovf_seen;
    b0 = beats;
    send(8'h20, 1'b0, 1'b0, 1'b1, 0);
    step(0);
    send(8'h60, 1'b1, 1'b0, 1'b1, 0);
    step(0);
    for (int i = 0; i < N; i++) step(1);
    send(8'hA0, 1'b1, 1'b0, 1'b1, 1);
    drain("coinc", 1);
    chk("coinc_ovf", 32'(ovf_seen - o0), 32'd0);
    chk("coinc_beats", 32'(beats - b0), 32'd192);

    // Full line with random backpressure
    o0 = ovf_seen;
    b0 = beats;
    users_seen = 0;
    lasts_seen = 0;
    last_pos   = -1;
    k   = 0;
    cyc = 0;
    while ((k < KPL || exp_data.size() != 0) && cyc < 60000) begin
      if (k < KPL && exp_data.size() <= N) begin
        send(8'(k * 5), (k % 2) == 1, k == 0, 1'b1, 2);
        k++;
      end else begin
        step(2);
      end
      cyc++;
    end
    chk("line_drained", 32'(exp_data.size()), 32'd0);
    chk("line_beats", 32'(beats - b0), 32'd12288);
    chk("line_users", 32'(users_seen), 32'd1);
    chk("line_lasts", 32'(lasts_seen), 32'd1);
    chk("line_last_pos", 32'(last_pos - b0), 32'd12287);
    chk("line_ovf", 32'(ovf_seen - o0), 32'd0);
    drain("line", 1);

    // Reset in the middle of a kernel
    b0 = beats;
    send(8'h30, 1'b0, 1'b0, 1'b1, 1);
    cyc = 0;
    while ((beats - b0) < 21 && cyc < 200) begin
      step(1);
      cyc++;
    end
    chk("mid_beats", 32'(beats - b0), 32'd21);
    aresetn = 1'b0;
    exp_data.delete();
    exp_user.delete();
    exp_last.delete();
    step(1);
    chk("mid_rst_valid", 32'(tvalid), 32'd0);
    chk("mid_rst_tdata", 32'(tdata), 32'd0);
    step(1);
    aresetn = 1'b1;
    kcnt = 0;
    step(1);
    chk("post_rst_valid", 32'(tvalid), 32'd0);
    b0 = beats;
    send(8'h80, 1'b0, 1'b0, 1'b1, 1);
    drain("post_rst", 1);
    chk("post_rst_beats", 32'(beats - b0), 32'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
